// File: rtl/ins_dispatcher_pkg.sv
// Shared constants for the instruction dispatcher: type codes, field positions,
// decoded field payloads and opcode legality helpers.
package ins_dispatcher_pkg;

  localparam int unsigned INST_W = 64;
  localparam int unsigned ADDR_W = 32;

  localparam logic [1:0] INS_LD   = 2'b00;
  localparam logic [1:0] INS_CALC = 2'b01;
  localparam logic [1:0] INS_WR   = 2'b10;
  localparam logic [1:0] INS_CFG  = 2'b11;

  localparam int unsigned TYPE_MSB    = 63;
  localparam int unsigned TYPE_LSB    = 62;
  localparam int unsigned OP_MSB      = 61;
  localparam int unsigned OP_LSB      = 58;
  localparam int unsigned BUF_MSB     = 57;
  localparam int unsigned BUF_LSB     = 52;
  localparam int unsigned SIZE_MSB    = 39;
  localparam int unsigned SIZE_LSB    = 32;
  localparam int unsigned ADDR_MSB    = 31;
  localparam int unsigned ADDR_LSB    = 0;
  localparam int unsigned CUT_Y_BIT   = 59;
  localparam int unsigned IS_NEW_BIT  = 58;
  localparam int unsigned PE_MSB      = 57;
  localparam int unsigned PE_LSB      = 52;
  localparam int unsigned PAD_MSB     = 51;
  localparam int unsigned PAD_LSB     = 48;
  localparam int unsigned PIX_MSB     = 47;
  localparam int unsigned PIX_LSB     = 40;
  localparam int unsigned IDX_MSB     = 39;
  localparam int unsigned IDX_LSB     = 32;
  localparam int unsigned LT_MSB      = 61;
  localparam int unsigned LT_LSB      = 58;
  localparam int unsigned POOL_BIT    = 57;
  localparam int unsigned RELU_BIT    = 56;
  localparam int unsigned IN_SEG_MSB  = 55;
  localparam int unsigned IN_SEG_LSB  = 52;
  localparam int unsigned OUT_SEG_MSB = 51;
  localparam int unsigned OUT_SEG_LSB = 48;
  localparam int unsigned IN_W_MSB    = 47;
  localparam int unsigned IN_W_LSB    = 40;
  localparam int unsigned OUT_W_MSB   = 39;
  localparam int unsigned OUT_W_LSB   = 32;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  typedef struct packed {
    logic [3:0]        op;
    logic [5:0]        buf_id;
    logic [7:0]        size;
    logic [ADDR_W-1:0] addr;
  } rd_fields_t;

  typedef struct packed {
    logic       cut_y;
    logic       is_new;
    logic [5:0] pe_id;
    logic [3:0] pad_code;
    logic [7:0] pix_num;
    logic [7:0] idx_num;
  } calc_fields_t;

  typedef struct packed {
    logic [3:0]        op;
    logic [5:0]        buf_id;
    logic [ADDR_W-1:0] addr;
  } wr_fields_t;

  typedef struct packed {
    logic [3:0] layer_type;
    logic       pool;
    logic       relu;
    logic [3:0] in_seg;
    logic [3:0] out_seg;
    logic [7:0] in_w;
    logic [7:0] out_w;
  } cfg_fields_t;

  localparam int unsigned RD_FW   = $bits(rd_fields_t);
  localparam int unsigned CALC_FW = $bits(calc_fields_t);
  localparam int unsigned WR_FW   = $bits(wr_fields_t);
  localparam int unsigned CFG_FW  = $bits(cfg_fields_t);

  // Load opcodes understood by the read unit
  function automatic logic is_legal_rd_op(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Save opcodes understood by the write unit
  function automatic logic is_legal_wr_op(input logic [3:0] op);
    case (op)
      4'd0, 4'd2, 4'd3, 4'd4, 4'd5: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  // Layer types 0..5 exist; anything above is rejected
  function automatic logic is_legal_lt(input logic [3:0] lt);
    return (lt <= 4'd5);
  endfunction

endpackage

// File: rtl/ins_field_decode.sv
// Combinational split of one instruction word into per-unit field payloads
// plus a legality bit for the word's own type.
module ins_field_decode
  import ins_dispatcher_pkg::*;
(
  input  logic [INST_W-1:0]  i_ins,
  output logic [1:0]         o_type_c,
  output logic [RD_FW-1:0]   o_rd_c,
  output logic [CALC_FW-1:0] o_calc_c,
  output logic [WR_FW-1:0]   o_wr_c,
  output logic [CFG_FW-1:0]  o_cfg_c,
  output logic               o_legal_c
);

  rd_fields_t   w_rd;
  calc_fields_t w_calc;
  wr_fields_t   w_wr;
  cfg_fields_t  w_cfg;

  // Field extraction for every instruction flavour
  always_comb begin
    w_rd.op          = i_ins[OP_MSB:OP_LSB];
    w_rd.buf_id      = i_ins[BUF_MSB:BUF_LSB];
    w_rd.size        = i_ins[SIZE_MSB:SIZE_LSB];
    w_rd.addr        = i_ins[ADDR_MSB:ADDR_LSB];

    w_calc.cut_y     = i_ins[CUT_Y_BIT];
    w_calc.is_new    = i_ins[IS_NEW_BIT];
    w_calc.pe_id     = i_ins[PE_MSB:PE_LSB];
    w_calc.pad_code  = i_ins[PAD_MSB:PAD_LSB];
    w_calc.pix_num   = i_ins[PIX_MSB:PIX_LSB];
    w_calc.idx_num   = i_ins[IDX_MSB:IDX_LSB];

    w_wr.op          = i_ins[OP_MSB:OP_LSB];
    w_wr.buf_id      = i_ins[BUF_MSB:BUF_LSB];
    w_wr.addr        = i_ins[ADDR_MSB:ADDR_LSB];

    w_cfg.layer_type = i_ins[LT_MSB:LT_LSB];
    w_cfg.pool       = i_ins[POOL_BIT];
    w_cfg.relu       = i_ins[RELU_BIT];
    w_cfg.in_seg     = i_ins[IN_SEG_MSB:IN_SEG_LSB];
    w_cfg.out_seg    = i_ins[OUT_SEG_MSB:OUT_SEG_LSB];
    w_cfg.in_w       = i_ins[IN_W_MSB:IN_W_LSB];
    w_cfg.out_w      = i_ins[OUT_W_MSB:OUT_W_LSB];
  end

  // Legality depends only on the opcode/layer type of the word's own type; calc is always legal
  always_comb begin
    o_legal_c = 1'b1;
    case (i_ins[TYPE_MSB:TYPE_LSB])
      INS_LD:  o_legal_c = is_legal_rd_op(w_rd.op);
      INS_WR:  o_legal_c = is_legal_wr_op(w_wr.op);
      INS_CFG: o_legal_c = is_legal_lt(w_cfg.layer_type);
      default: o_legal_c = 1'b1;
    endcase
  end

  assign o_type_c = i_ins[TYPE_MSB:TYPE_LSB];
  assign o_rd_c   = w_rd;
  assign o_calc_c = w_calc;
  assign o_wr_c   = w_wr;
  assign o_cfg_c  = w_cfg;

endmodule

// File: rtl/ins_dispatcher.sv
// Instruction dispatcher: routes load/calc/save words to their units through a
// single registered holding slot and applies config words once all units drain.
// Optional build macro INS_DISPATCH_CNT_EN adds per-type handshake counters.
module ins_dispatcher
  import ins_dispatcher_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ins_valid,
  output logic        ins_ready,
  input  logic [63:0] ins,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [3:0]  rd_op,
  output logic [5:0]  rd_buf_id,
  output logic [7:0]  rd_size,
  output logic [31:0] rd_addr,
  output logic        calc_valid,
  input  logic        calc_ready,
  output logic        calc_cut_y,
  output logic        calc_is_new,
  output logic [5:0]  calc_pe_id,
  output logic [3:0]  calc_pad_code,
  output logic [7:0]  calc_pix_num,
  output logic [7:0]  calc_idx_num,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [3:0]  wr_op,
  output logic [5:0]  wr_buf_id,
  output logic [31:0] wr_addr,
  input  logic        rd_busy,
  input  logic        calc_busy,
  input  logic        wr_busy,
  output logic [3:0]  cfg_layer_type,
  output logic        cfg_pool,
  output logic        cfg_relu,
  output logic [3:0]  cfg_in_seg,
  output logic [3:0]  cfg_out_seg,
  output logic [7:0]  cfg_in_w,
  output logic [7:0]  cfg_out_w,
  output logic        cfg_update,
  output logic        err,
  output logic [63:0] err_ins
`ifdef INS_DISPATCH_CNT_EN
  ,
  output logic [31:0] cnt_ld,
  output logic [31:0] cnt_calc,
  output logic [31:0] cnt_wr,
  output logic [31:0] cnt_cfg
`endif
);

  logic [1:0]         w_type;
  logic [RD_FW-1:0]   w_rd_bits;
  logic [CALC_FW-1:0] w_calc_bits;
  logic [WR_FW-1:0]   w_wr_bits;
  logic [CFG_FW-1:0]  w_cfg_bits;
  logic               w_legal;

  ins_field_decode u_decode (
    .i_ins     (ins),
    .o_type_c  (w_type),
    .o_rd_c    (w_rd_bits),
    .o_calc_c  (w_calc_bits),
    .o_wr_c    (w_wr_bits),
    .o_cfg_c   (w_cfg_bits),
    .o_legal_c (w_legal)
  );

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_rd_valid, r_calc_valid, r_wr_valid;
  rd_fields_t   r_rd;
  calc_fields_t r_calc;
  wr_fields_t   r_wr;
  cfg_fields_t  r_cfg, r_cfg_pend;
  logic         r_cfg_update;
  logic         r_err;
  logic [63:0]  r_err_ins;

  logic w_rd_fire, w_calc_fire, w_wr_fire;
  logic w_slot_valid, w_slot_fire;
  logic w_ins_ready, w_drain_done;
  logic w_accept, w_acc_rd, w_acc_calc, w_acc_wr, w_acc_cfg, w_acc_ill;

  assign w_rd_fire    = r_rd_valid & rd_ready;
  assign w_calc_fire  = r_calc_valid & calc_ready;
  assign w_wr_fire    = r_wr_valid & wr_ready;
  assign w_slot_valid = r_rd_valid | r_calc_valid | r_wr_valid;
  assign w_slot_fire  = w_rd_fire | w_calc_fire | w_wr_fire;

  assign w_accept   = ins_valid & w_ins_ready;
  assign w_acc_rd   = w_accept & w_legal & (w_type == INS_LD);
  assign w_acc_calc = w_accept & w_legal & (w_type == INS_CALC);
  assign w_acc_wr   = w_accept & w_legal & (w_type == INS_WR);
  assign w_acc_cfg  = w_accept & w_legal & (w_type == INS_CFG);
  assign w_acc_ill  = w_accept & ~w_legal;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // Next state, acceptance window and drain completion
  always_comb begin
    w_state_nxt  = r_state;
    w_ins_ready  = 1'b0;
    w_drain_done = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_ins_ready = ~w_slot_valid | w_slot_fire;
        if (ins_valid && w_ins_ready && w_legal && (w_type == INS_CFG)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!w_slot_valid && !rd_busy && !calc_busy && !wr_busy) begin
          w_state_nxt  = ST_RUN;
          w_drain_done = 1'b1;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Holding slot: a valid drops only on its handshake, reloads on a new accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid   <= 1'b0;
      r_calc_valid <= 1'b0;
      r_wr_valid   <= 1'b0;
      r_rd         <= '0;
      r_calc       <= '0;
      r_wr         <= '0;
    end else begin
      r_rd_valid   <= w_acc_rd   | (r_rd_valid   & ~rd_ready);
      r_calc_valid <= w_acc_calc | (r_calc_valid & ~calc_ready);
      r_wr_valid   <= w_acc_wr   | (r_wr_valid   & ~wr_ready);
      if (w_acc_rd)   r_rd   <= w_rd_bits;
      if (w_acc_calc) r_calc <= w_calc_bits;
      if (w_acc_wr)   r_wr   <= w_wr_bits;
    end
  end

  // Config capture on accept, application when the drain completes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_pend   <= '0;
      r_cfg        <= '0;
      r_cfg_update <= 1'b0;
    end else begin
      if (w_acc_cfg)    r_cfg_pend <= w_cfg_bits;
      if (w_drain_done) r_cfg      <= r_cfg_pend;
      r_cfg_update <= w_drain_done;
    end
  end

  // Sticky error flag; only the first offending word is kept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_err_ins <= '0;
    end else if (w_acc_ill) begin
      r_err <= 1'b1;
      if (!r_err) r_err_ins <= ins;
    end
  end

`ifdef INS_DISPATCH_CNT_EN
  logic [31:0] r_cnt_ld, r_cnt_calc, r_cnt_wr, r_cnt_cfg;

  // Completed handshakes per type and applied configs, free-running wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_ld   <= '0;
      r_cnt_calc <= '0;
      r_cnt_wr   <= '0;
      r_cnt_cfg  <= '0;
    end else begin
      if (w_rd_fire)    r_cnt_ld   <= r_cnt_ld   + 32'd1;
      if (w_calc_fire)  r_cnt_calc <= r_cnt_calc + 32'd1;
      if (w_wr_fire)    r_cnt_wr   <= r_cnt_wr   + 32'd1;
      if (w_drain_done) r_cnt_cfg  <= r_cnt_cfg  + 32'd1;
    end
  end

  assign cnt_ld   = r_cnt_ld;
  assign cnt_calc = r_cnt_calc;
  assign cnt_wr   = r_cnt_wr;
  assign cnt_cfg  = r_cnt_cfg;
`endif

  assign ins_ready      = w_ins_ready;
  assign rd_valid       = r_rd_valid;
  assign rd_op          = r_rd.op;
  assign rd_buf_id      = r_rd.buf_id;
  assign rd_size        = r_rd.size;
  assign rd_addr        = r_rd.addr;
  assign calc_valid     = r_calc_valid;
  assign calc_cut_y     = r_calc.cut_y;
  assign calc_is_new    = r_calc.is_new;
  assign calc_pe_id     = r_calc.pe_id;
  assign calc_pad_code  = r_calc.pad_code;
  assign calc_pix_num   = r_calc.pix_num;
  assign calc_idx_num   = r_calc.idx_num;
  assign wr_valid       = r_wr_valid;
  assign wr_op          = r_wr.op;
  assign wr_buf_id      = r_wr.buf_id;
  assign wr_addr        = r_wr.addr;
  assign cfg_layer_type = r_cfg.layer_type;
  assign cfg_pool       = r_cfg.pool;
  assign cfg_relu       = r_cfg.relu;
  assign cfg_in_seg     = r_cfg.in_seg;
  assign cfg_out_seg    = r_cfg.out_seg;
  assign cfg_in_w       = r_cfg.in_w;
  assign cfg_out_w      = r_cfg.out_w;
  assign cfg_update     = r_cfg_update;
  assign err            = r_err;
  assign err_ins        = r_err_ins;

endmodule

// File: tb/tb_ins_dispatcher.sv
// Testbench for ins_dispatcher: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level model of the dispatcher.
module tb_ins_dispatcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ins_valid, ins_ready;
  logic [63:0] ins;
  logic        rd_valid, rd_ready;
  logic [3:0]  rd_op;
  logic [5:0]  rd_buf_id;
  logic [7:0]  rd_size;
  logic [31:0] rd_addr;
  logic        calc_valid, calc_ready, calc_cut_y, calc_is_new;
  logic [5:0]  calc_pe_id;
  logic [3:0]  calc_pad_code;
  logic [7:0]  calc_pix_num, calc_idx_num;
  logic        wr_valid, wr_ready;
  logic [3:0]  wr_op;
  logic [5:0]  wr_buf_id;
  logic [31:0] wr_addr;
  logic        rd_busy, calc_busy, wr_busy;
  logic [3:0]  cfg_layer_type, cfg_in_seg, cfg_out_seg;
  logic        cfg_pool, cfg_relu, cfg_update, err;
  logic [7:0]  cfg_in_w, cfg_out_w;
  logic [63:0] err_ins;
`ifdef INS_DISPATCH_CNT_EN
  logic [31:0] cnt_ld, cnt_calc, cnt_wr, cnt_cfg;
`endif

  ins_dispatcher dut (
    .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_op(rd_op), .rd_buf_id(rd_buf_id),
    .rd_size(rd_size), .rd_addr(rd_addr),
    .calc_valid(calc_valid), .calc_ready(calc_ready), .calc_cut_y(calc_cut_y),
    .calc_is_new(calc_is_new), .calc_pe_id(calc_pe_id), .calc_pad_code(calc_pad_code),
    .calc_pix_num(calc_pix_num), .calc_idx_num(calc_idx_num),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_op(wr_op), .wr_buf_id(wr_buf_id),
    .wr_addr(wr_addr),
    .rd_busy(rd_busy), .calc_busy(calc_busy), .wr_busy(wr_busy),
    .cfg_layer_type(cfg_layer_type), .cfg_pool(cfg_pool), .cfg_relu(cfg_relu),
    .cfg_in_seg(cfg_in_seg), .cfg_out_seg(cfg_out_seg), .cfg_in_w(cfg_in_w),
    .cfg_out_w(cfg_out_w), .cfg_update(cfg_update), .err(err), .err_ins(err_ins)
`ifdef INS_DISPATCH_CNT_EN
    , .cnt_ld(cnt_ld), .cnt_calc(cnt_calc), .cnt_wr(cnt_wr), .cnt_cfg(cnt_cfg)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one pending dispatch, a held config word, last word seen per unit
  bit        m_sv;
  bit [1:0]  m_st;
  bit [63:0] m_rdw, m_cw, m_ww, m_cfgw, m_pendw, m_errw;
  bit        m_drain, m_upd, m_err, m_acc;
  bit [31:0] m_cnt [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input bit [63:0] w);
    bit [3:0] op;
    op = w[61:58];
    case (w[63:62])
      2'd0:    return op inside {4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7};
      2'd2:    return op inside {4'd0, 4'd2, 4'd3, 4'd4, 4'd5};
      2'd3:    return op <= 4'd5;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_sv = 0; m_st = 0; m_rdw = 0; m_cw = 0; m_ww = 0; m_cfgw = 0; m_pendw = 0;
    m_errw = 0; m_drain = 0; m_upd = 0; m_err = 0; m_acc = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // One clock: drive inputs, compare outputs at the falling edge, advance the model
  task automatic step(input bit v, input bit [63:0] w, input bit rr, input bit cr,
                      input bit wrr, input bit rb, input bit cb, input bit wb, input bit r);
    bit fire, rdy, exit_d;
    ins_valid = v; ins = w; rd_ready = rr; calc_ready = cr; wr_ready = wrr;
    rd_busy = rb; calc_busy = cb; wr_busy = wb; rst = r;
    #4;
    fire = m_sv && ((m_st == 2'd0 && rr) || (m_st == 2'd1 && cr) || (m_st == 2'd2 && wrr));
    rdy  = !m_drain && (!m_sv || fire);
    chk("ins_ready", ins_ready, rdy);
    chk("rd_valid", rd_valid, m_sv && m_st == 2'd0);
    chk("calc_valid", calc_valid, m_sv && m_st == 2'd1);
    chk("wr_valid", wr_valid, m_sv && m_st == 2'd2);
    chk("rd_fields", {rd_op, rd_buf_id, rd_size, rd_addr},
        {m_rdw[61:58], m_rdw[57:52], m_rdw[39:32], m_rdw[31:0]});
    chk("calc_fields", {calc_cut_y, calc_is_new, calc_pe_id, calc_pad_code, calc_pix_num, calc_idx_num},
        {m_cw[59], m_cw[58], m_cw[57:52], m_cw[51:48], m_cw[47:40], m_cw[39:32]});
    chk("wr_fields", {wr_op, wr_buf_id, wr_addr}, {m_ww[61:58], m_ww[57:52], m_ww[31:0]});
    chk("cfg_fields", {cfg_layer_type, cfg_pool, cfg_relu, cfg_in_seg, cfg_out_seg, cfg_in_w, cfg_out_w},
        {m_cfgw[61:58], m_cfgw[57], m_cfgw[56], m_cfgw[55:52], m_cfgw[51:48], m_cfgw[47:40], m_cfgw[39:32]});
    chk("cfg_update", cfg_update, m_upd);
    chk("err", err, m_err);
    chk("err_ins", err_ins, m_errw);
`ifdef INS_DISPATCH_CNT_EN
    chk("cnt_ld", cnt_ld, m_cnt[0]);
    chk("cnt_calc", cnt_calc, m_cnt[1]);
    chk("cnt_wr", cnt_wr, m_cnt[2]);
    chk("cnt_cfg", cnt_cfg, m_cnt[3]);
`endif
    if (r) begin
      model_reset();
    end else begin
      m_acc  = v && rdy;
      exit_d = m_drain && !m_sv && !rb && !cb && !wb;
      m_upd  = exit_d;
      if (exit_d) begin
        m_drain = 0; m_cfgw = m_pendw; m_cnt[3]++;
      end
      if (fire) begin
        m_sv = 0; m_cnt[m_st]++;
      end
      if (m_acc) begin
        if (!legal(w)) begin
          if (!m_err) m_errw = w;
          m_err = 1;
        end else if (w[63:62] == 2'd3) begin
          m_drain = 1; m_pendw = w;
        end else begin
          m_sv = 1; m_st = w[63:62];
          case (w[63:62])
            2'd0:    m_rdw = w;
            2'd1:    m_cw = w;
            default: m_ww = w;
          endcase
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic bit [63:0] rand_word();
    bit [63:0] w;
    bit [3:0] ldops [6];
    bit [3:0] wrops [5];
    ldops = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7};
    wrops = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5};
    w = {$urandom, $urandom};
    w[63:62] = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 9) != 0) begin
      case (w[63:62])
        2'd0:    w[61:58] = ldops[$urandom_range(0, 5)];
        2'd2:    w[61:58] = wrops[$urandom_range(0, 4)];
        2'd3:    w[61:58] = 4'($urandom_range(0, 5));
        default: ;
      endcase
    end
    return w;
  endfunction

  bit [63:0] w_ld, w_calc, w_sv, w_cfg, w_bad1, w_bad2;
  bit [63:0] seq [4];
  int upd_cnt;

  initial begin
    ins_valid = 0; ins = 0; rd_ready = 0; calc_ready = 0; wr_ready = 0;
    rd_busy = 0; calc_busy = 0; wr_busy = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("reset_rd_valid", rd_valid, 1'b0);
    chk("reset_calc_valid", calc_valid, 1'b0);
    chk("reset_wr_valid", wr_valid, 1'b0);
    chk("reset_ins_ready", ins_ready, 1'b1);
    chk("reset_cfg_update", cfg_update, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_err_ins", err_ins, 64'd0);
    chk("reset_cfg_in_w", cfg_in_w, 8'd0);

    // Back-to-back loads with rd_ready high
    w_ld = {2'b00, 4'd4, 6'd5, 12'd0, 8'h10, 32'h8000_0000};
    for (int i = 0; i < 4; i++) begin
      step(1, w_ld, 1, 1, 1, 0, 0, 0, 0);
      chk("b2b_rd_valid", rd_valid, 1'b1);
      chk("b2b_ins_ready", ins_ready, 1'b1);
      chk("b2b_rd_addr", rd_addr, 32'h8000_0000);
    end
    chk("b2b_rd_op", rd_op, 4'd4);
    chk("b2b_rd_buf_id", rd_buf_id, 6'd5);
    chk("b2b_rd_size", rd_size, 8'h10);
    step(0, 0, 1, 1, 1, 0, 0, 0, 0);
    chk("b2b_rd_drop", rd_valid, 1'b0);

    // Calc held under backpressure
    w_calc = {2'b01, 2'b00, 1'b0, 1'b0, 6'd3, 4'd0, 8'd20, 8'd9, 32'd0};
    step(1, w_calc, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_calc_valid", calc_valid, 1'b1);
      chk("bp_pix_idx_pe", {calc_pix_num, calc_idx_num, calc_pe_id}, {8'd20, 8'd9, 6'd3});
      chk("bp_ins_ready", ins_ready, 1'b0);
      step(1, w_ld, 1, 0, 1, 0, 0, 0, 0);
    end
    step(0, 0, 1, 1, 1, 0, 0, 0, 0);
    chk("bp_calc_fired", calc_valid, 1'b0);
    step(0, 0, 1, 1, 1, 0, 0, 0, 0);

    // Save then config while the write unit stays busy
    w_sv  = {2'b10, 4'd2, 6'd1, 20'd0, 32'h0000_1000};
    w_cfg = {2'b11, 4'd2, 1'b0, 1'b1, 4'd3, 4'd0, 8'd28, 8'd0, 32'd0};
    step(1, w_sv, 1, 1, 1, 0, 0, 1, 0);
    step(1, w_cfg, 1, 1, 1, 0, 0, 1, 0);
    upd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      chk("drain_ins_ready", ins_ready, 1'b0);
      if (cfg_update) upd_cnt++;
      step(1, w_ld, 1, 1, 1, 0, 0, 1, 0);
    end
    if (cfg_update) upd_cnt++;
    step(0, 0, 1, 1, 1, 0, 0, 0, 0);
    chk("drain_update_timing", cfg_update, 1'b1);
    upd_cnt++;
    chk("drain_layer_type", cfg_layer_type, 4'd2);
    chk("drain_in_w", cfg_in_w, 8'd28);
    chk("drain_relu_seg", {cfg_relu, cfg_in_seg}, {1'b1, 4'd3});
    step(0, 0, 1, 1, 1, 0, 0, 0, 0);
    if (cfg_update) upd_cnt++;
    chk("drain_update_once", upd_cnt, 1);

    // Illegal load then illegal save, followed by a legal load
    w_bad1 = {2'b00, 4'd3, 6'd7, 20'd0, 32'h0000_1234};
    w_bad2 = {2'b10, 4'd1, 6'd2, 20'd0, 32'h0000_5678};
    step(1, w_bad1, 1, 1, 1, 0, 0, 0, 0);
    chk("ill_no_rd", rd_valid, 1'b0);
    chk("ill_err", err, 1'b1);
    step(1, w_bad2, 1, 1, 1, 0, 0, 0, 0);
    chk("ill_no_wr", wr_valid, 1'b0);
    chk("ill_err_ins_first", err_ins, 64'h0C70_0000_0000_1234);
    step(1, w_ld, 1, 1, 1, 0, 0, 0, 0);
    chk("ill_then_legal", rd_valid, 1'b1);

    // Type interleave with all readies high
    seq[0] = w_ld; seq[1] = w_calc; seq[2] = w_sv; seq[3] = w_ld;
    for (int i = 0; i < 4; i++) begin
      step(1, seq[i], 1, 1, 1, 0, 0, 0, 0);
      chk("ilv_valids", {rd_valid, calc_valid, wr_valid},
          (i == 1) ? 3'b010 : (i == 2) ? 3'b001 : 3'b100);
    end
    step(0, 0, 1, 1, 1, 0, 0, 0, 0);

    // Reset while a config is draining
    step(1, w_cfg, 1, 1, 1, 1, 0, 0, 0);
    step(0, 0, 1, 1, 1, 1, 0, 0, 0);
    chk("rstd_in_drain", ins_ready, 1'b0);
    step(0, 0, 1, 1, 1, 1, 0, 0, 1);
    chk("rstd_ins_ready", ins_ready, 1'b1);
    chk("rstd_cfg_update", cfg_update, 1'b0);
    chk("rstd_cfg_cleared", {cfg_layer_type, cfg_in_w}, 12'd0);
    chk("rstd_err_cleared", err, 1'b0);
    step(0, 0, 1, 1, 1, 0, 0, 0, 0);
    chk("rstd_no_update", cfg_update, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step(bit'($urandom_range(0, 9) < 7), rand_word(),
           bit'($urandom_range(0, 9) < 7), bit'($urandom_range(0, 9) < 7),
           bit'($urandom_range(0, 9) < 7),
           bit'($urandom_range(0, 9) < 2), bit'($urandom_range(0, 9) < 2),
           bit'($urandom_range(0, 9) < 2), bit'($urandom_range(0, 199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ins_dispatcher.md
Name: ins_dispatcher

Overview:
- Instruction decoder and dispatcher: consumes the 64-bit instruction stream produced by the host/instruction fetcher and decodes the type field [63:62].
- Routes load (00), calc (01) and save (10) instructions to the read, PE-calc and write units over valid/ready handshakes.
- Config instructions (11) are applied to layer configuration registers only after all units drain.
- Sits between the instruction FIFO and the rd/calc/wr controllers.

Parameters:
- INST_W, 64, instruction width; fixed by the instruction format.
- ADDR_W, 32, DDR address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ins_valid  in  1  instruction valid
- ins_ready  out  1  instruction accepted when valid&ready
- ins  in  64  instruction word
- rd_valid / rd_ready  out / in  1 / 1  load handshake
- rd_op, rd_buf_id, rd_size, rd_addr  out  4, 6, 8, 32  from [61:58], [57:52], [39:32], [31:0]
- calc_valid / calc_ready  out / in  1 / 1  calc handshake
- calc_cut_y, calc_is_new, calc_pe_id, calc_pad_code, calc_pix_num, calc_idx_num  out  1, 1, 6, 4, 8, 8  from [59], [58], [57:52], [51:48], [47:40], [39:32]
- wr_valid / wr_ready  out / in  1 / 1  save handshake
- wr_op, wr_buf_id, wr_addr  out  4, 6, 32  from [61:58], [57:52], [31:0]
- rd_busy, calc_busy, wr_busy  in  1 each  unit still executing
- cfg_layer_type  out  4  from [61:58]
- cfg_pool, cfg_relu  out  1, 1  from [57], [56]
- cfg_in_seg, cfg_out_seg  out  4, 4  from [55:52], [51:48]
- cfg_in_w, cfg_out_w  out  8, 8  from [47:40], [39:32]
- cfg_update  out  1  one-cycle pulse when cfg_* change
- err  out  1  sticky illegal-instruction flag
- err_ins  out  64  first illegal instruction word

Behaviour:
- Reset:
  - All valids, cfg_update and err are 0.
  - All field outputs, cfg_* and err_ins are 0; state is RUN.
- States:
  - RUN: accepting instructions.
  - DRAIN: config instruction held, waiting for the pipeline to empty.
- Output holding stage: one registered output slot per unit. Only one slot is valid at a time, so in-order dispatch is preserved.
- Latency: an instruction accepted at cycle N asserts its valid at cycle N+1 with registered fields.
- RUN: ins_ready = !slot_valid || slot_fire.
  - slot_fire = the currently valid target handshake completes this cycle.
  - This allows one instruction per cycle when downstream is always ready.
- Valid stays high and fields stay stable until ready. Valid never deasserts without a handshake, except on reset.
- Config instruction accepted in RUN:
  - Latch the word and go to DRAIN; ins_ready=0 while in DRAIN.
  - DRAIN → RUN when no slot is valid and rd_busy=calc_busy=wr_busy=0.
  - On that cycle cfg_* registers load and cfg_update pulses for one cycle.
  - The next instruction can be accepted the cycle after the return to RUN.
- Illegal instructions:
  - Illegal cases: load op ∉ {0,1,4,5,6,7}; save op ∉ {0,2,3,4,5}; config layer_type > 5.
  - The instruction is consumed (handshake completes) and not dispatched.
  - err is set; err_ins captures the word only if err was 0.
  - cfg is untouched and the state stays RUN.
- Calc has no opcode check. Bits [61:60] are ignored.
- Simultaneous slot_fire and new accept: the slot reloads with the new instruction. The valid for a different unit rises the next cycle, and the old valid falls.
- Busy inputs gate only the DRAIN exit, never load/calc/save dispatch.
- Reset mid-DRAIN or mid-handshake: the pending instruction is discarded and everything returns to reset values.

Optional Feature:
- INS_DISPATCH_CNT_EN: adds outputs cnt_ld, cnt_calc, cnt_wr, cnt_cfg (32 bits each, wrap at 2^32).
  - Each counts completed downstream handshakes per type; cnt_cfg counts cfg_update pulses.
  - Illegal instructions are not counted. All counters are 0 after reset.
- Without the macro: no counter ports or logic.

Decomposition:
- Add to INS_CONST:
  - type codes INS_LD=2'b00, INS_CALC=2'b01, INS_WR=2'b10, INS_CFG=2'b11;
  - field LSB/MSB localparams for every field listed above;
  - legality functions is_legal_rd_op, is_legal_wr_op, is_legal_lt.
- Sub-module ins_field_decode: purely combinational split of the 64-bit word into typed fields plus a legal bit. Instantiated once on ins.

Test Plan:
- Back-to-back loads, rd_ready=1:
  - Stimulus: ins=0x0_05_00_10_8000_0000 pattern with op=4, buf=5, size=0x10, addr=0x80000000, four words over consecutive cycles.
  - Response: rd_valid high for 4 cycles from cycle 1; fields match; ins_ready stays 1.
- Backpressure:
  - Stimulus: a calc instruction (pe_id=3, pix=20, idx=9) with calc_ready low for 5 cycles.
  - Response: calc_valid held with stable fields; ins_ready=0 until the fire cycle.
- Config drain:
  - Stimulus: a save instruction, then a config with layer_type=2, relu=1, in_seg=3, in_w=28, while wr_busy=1 for 10 cycles.
  - Response: cfg_update pulses exactly once, the cycle after wr_busy falls; cfg_layer_type=2, cfg_in_w=28.
- Illegal opcodes:
  - Stimulus: load op=3, then save op=1.
  - Response: err=1; err_ins = first word; no rd_valid/wr_valid; the following legal load dispatches normally.
- Type interleave:
  - Stimulus: ld, calc, wr, ld with all readies=1.
  - Response: valids appear in the same order, one per cycle.
  - With INS_DISPATCH_CNT_EN: cnt_ld=2, cnt_calc=1, cnt_wr=1.
- Reset during DRAIN:
  - Stimulus: assert rst while in DRAIN.
  - Response: next cycle all outputs are at reset values and ins_ready=1; cfg_update is never pulsed.
